// File: rtl/uart_core_param.sv
// Full-duplex 16x-oversampled UART with parameterised data width and stop bits.
// Define UART_PARITY_EN to add a parity bit; PARITY_ODD then selects odd parity.
module uart_core_param #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              RXD,
  output logic              TXD,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_frame_err,
  output logic              rx_parity_err,
  output logic              rx_overrun
);

  localparam int OS_DIV   = CLK_HZ / (BAUD * 16);
  localparam int OS_W     = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam int BIT_CLKS = 16 * OS_DIV;
  localparam int BT_W     = $clog2(BIT_CLKS);
  localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OS_DIV - 1);
  localparam logic [BT_W-1:0] BT_LAST   = BT_W'(BIT_CLKS - 1);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_W - 1);
  localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);

  if (DATA_W < 5 || DATA_W > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_core_param: DATA_W 5..9, STOP_BITS 1..2, PARITY_ODD 0..1");
  end

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

`ifdef UART_PARITY_EN
  function automatic logic par_bit(input logic [DATA_W-1:0] d);
    return (^d) ^ 1'(PARITY_ODD);
  endfunction
`endif

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP, RX_BREAK
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  logic [OS_W-1:0]   os_cnt;
  logic              os_tick;
  logic              rxd_p0, rxd_p1;
  rx_state_t         rx_state, rx_state_nxt;
  logic [3:0]        rx_tick, rx_bit;
  logic [1:0]        rx_samp;
  logic [DATA_W-1:0] rx_shreg;
  logic              rx_mid, rx_bit_end, rx_maj, rx_commit, rx_ferr_nxt, rx_perr_nxt;
  tx_state_t         tx_state, tx_state_nxt;
  logic [BT_W-1:0]   tx_timer;
  logic [3:0]        tx_bit, tx_bit_nxt;
  logic [DATA_W-1:0] tx_buf;
  logic              tx_bit_end, tx_buf_bit, txd_nxt;

  assign os_tick = (os_cnt == OS_LAST);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) os_cnt <= '0;
    else if (os_tick) os_cnt <= '0;
    else os_cnt <= os_cnt + 1'b1;
  end

  // RXD synchroniser stages p0 -> p1
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
    end else begin
      rxd_p0 <= RXD;
      rxd_p1 <= rxd_p0;
    end
  end

  assign rx_mid     = os_tick && (rx_tick == 4'd9);
  assign rx_bit_end = os_tick && (rx_tick == 4'd15);
  assign rx_maj     = maj3(rx_samp[0], rx_samp[1], rxd_p1);

  always_comb begin
    rx_state_nxt = rx_state;
    rx_commit    = 1'b0;
    rx_ferr_nxt  = 1'b0;
    case (rx_state)
      RX_IDLE:  if (!rxd_p1) rx_state_nxt = RX_START;
      RX_START: begin
        if (rx_mid && rx_maj) rx_state_nxt = RX_IDLE;
        else if (rx_bit_end) rx_state_nxt = RX_DATA;
      end
`ifdef UART_PARITY_EN
      RX_DATA:   if (rx_bit_end && rx_bit == DATA_LAST) rx_state_nxt = RX_PARITY;
      RX_PARITY: if (rx_bit_end) rx_state_nxt = RX_STOP;
`else
      RX_DATA:   if (rx_bit_end && rx_bit == DATA_LAST) rx_state_nxt = RX_STOP;
`endif
      RX_STOP: begin
        // Leave mid stop bit so the next start edge is caught without slip
        if (rx_mid) begin
          rx_commit    = 1'b1;
          rx_ferr_nxt  = !rx_maj;
          rx_state_nxt = rx_maj ? RX_IDLE : RX_BREAK;
        end
      end
      RX_BREAK: if (rxd_p1) rx_state_nxt = RX_IDLE;
      default:  rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_tick  <= '0;
      rx_bit   <= '0;
    end else begin
      rx_state <= rx_state_nxt;
      if (rx_state == RX_IDLE) begin
        rx_tick <= '0;
        rx_bit  <= '0;
      end else begin
        if (os_tick) rx_tick <= rx_tick + 4'd1;
        if (rx_state == RX_DATA && rx_bit_end) rx_bit <= rx_bit + 4'd1;
      end
    end
  end

`ifdef UART_PARITY_EN
  logic rx_par;
  always_ff @(posedge clock) begin
    if (rx_state == RX_PARITY && rx_mid) rx_par <= rx_maj;
  end
  assign rx_perr_nxt = (rx_par != par_bit(rx_shreg));
`else
  assign rx_perr_nxt = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (os_tick && rx_tick == 4'd7) rx_samp[0] <= rxd_p1;
    if (os_tick && rx_tick == 4'd8) rx_samp[1] <= rxd_p1;
    if (rx_state == RX_DATA && rx_mid) rx_shreg <= {rx_maj, rx_shreg[DATA_W-1:1]};
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (rx_commit && (!rx_valid || rx_ready)) begin
        rx_valid      <= 1'b1;
        rx_data       <= rx_shreg;
        rx_frame_err  <= rx_ferr_nxt;
        rx_parity_err <= rx_perr_nxt;
      end else if (rx_commit) begin
        rx_overrun <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign tx_ready   = (tx_state == TX_IDLE);
  assign tx_bit_end = (tx_timer == BT_LAST);

  always_comb begin
    tx_state_nxt = tx_state;
    tx_bit_nxt   = tx_bit;
    case (tx_state)
      TX_IDLE: if (tx_valid) begin
        tx_state_nxt = TX_START;
        tx_bit_nxt   = '0;
      end
      TX_START: if (tx_bit_end) tx_state_nxt = TX_DATA;
      TX_DATA: if (tx_bit_end) begin
        if (tx_bit == DATA_LAST) begin
`ifdef UART_PARITY_EN
          tx_state_nxt = TX_PARITY;
`else
          tx_state_nxt = TX_STOP;
`endif
          tx_bit_nxt = '0;
        end else begin
          tx_bit_nxt = tx_bit + 4'd1;
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: if (tx_bit_end) tx_state_nxt = TX_STOP;
`endif
      TX_STOP: if (tx_bit_end) begin
        if (tx_bit == STOP_LAST) tx_state_nxt = TX_IDLE;
        else tx_bit_nxt = tx_bit + 4'd1;
      end
      default: tx_state_nxt = TX_IDLE;
    endcase

    tx_buf_bit = 1'b1;
    for (int i = 0; i < DATA_W; i++) begin
      if (tx_bit_nxt == 4'(i)) tx_buf_bit = tx_buf[i];
    end

    // TXD is registered from the next state so the pin never glitches
    case (tx_state_nxt)
      TX_START:  txd_nxt = 1'b0;
      TX_DATA:   txd_nxt = tx_buf_bit;
`ifdef UART_PARITY_EN
      TX_PARITY: txd_nxt = par_bit(tx_buf);
`endif
      default:   txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_timer <= '0;
      tx_bit   <= '0;
      TXD      <= 1'b1;
    end else begin
      tx_state <= tx_state_nxt;
      tx_bit   <= tx_bit_nxt;
      TXD      <= txd_nxt;
      if (tx_state == TX_IDLE || tx_bit_end) tx_timer <= '0;
      else tx_timer <= tx_timer + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (tx_valid && tx_ready) tx_buf <= tx_data;
  end

endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench for uart_core_param at 4 clocks per os_tick (64 clocks per bit).
// Compile with +define+UART_PARITY_EN to exercise the parity build.
module tb_uart_core_param;

  localparam int OS  = 4;
  localparam int BIT = 16 * OS;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
  localparam logic [0:NBITS-1] A3_BITS = 11'b01100010101;
  localparam logic [0:NBITS-1] B2_BITS = 11'b00011110001;
`else
  localparam int NBITS = 10;
  localparam logic [0:NBITS-1] A3_BITS = 10'b0110001011;
  localparam logic [0:NBITS-1] B2_BITS = 10'b0001111001;
`endif

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       RXD = 1'b1;
  logic       TXD;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       rx_frame_err, rx_parity_err, rx_overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stop_cyc = 0;
  int rv_rise_cyc = 0;
  int rv_rise_cnt = 0;
  int ovr_cnt = 0;
  logic rv_q = 1'b0;

  uart_core_param #(
    .CLK_HZ(614_400), .BAUD(9600), .DATA_W(8), .STOP_BITS(1), .PARITY_ODD(0)
  ) dut (
    .clock(clock), .rst_n(rst_n), .RXD(RXD), .TXD(TXD),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err), .rx_overrun(rx_overrun)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (rx_valid && !rv_q) begin
      rv_rise_cyc = cyc;
      rv_rise_cnt = rv_rise_cnt + 1;
    end
    if (rx_overrun) ovr_cnt = ovr_cnt + 1;
    rv_q = rx_valid;
  end

  task automatic drive_rx_frame(input logic [7:0] d, input int stop_low_bits, input logic par_flip);
    RXD = 1'b0;
    repeat (BIT) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      RXD = d[i];
      repeat (BIT) @(negedge clock);
    end
`ifdef UART_PARITY_EN
    RXD = (^d) ^ par_flip;
    repeat (BIT) @(negedge clock);
`endif
    stop_cyc = cyc;
    if (stop_low_bits > 0) begin
      RXD = 1'b0;
      repeat (stop_low_bits * BIT) @(negedge clock);
    end
    RXD = 1'b1;
    repeat (BIT) @(negedge clock);
  endtask

  task automatic pulse_rx_ready();
    @(negedge clock);
    rx_ready = 1'b1;
    @(negedge clock);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (TXD !== 1'b1) begin errors++; $display("FAIL reset_txd got %b want 1", TXD); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %b want 1", tx_ready); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
    checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", rx_frame_err); end
    checks++; if (rx_parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err got %b want 0", rx_parity_err); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", rx_overrun); end
    rst_n = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_rx_basic();
    int n0 = rv_rise_cnt;
    int lat;
    drive_rx_frame(8'h55, 0, 1'b0);
    lat = rv_rise_cyc - (stop_cyc + BIT / 2);
    checks++; if (rv_rise_cnt !== n0 + 1) begin errors++; $display("FAIL rx55_count got %0d want %0d", rv_rise_cnt - n0, 1); end
    checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL rx55_data got %h want 55", rx_data); end
    checks++; if (rx_frame_err !== 1'b0 || rx_parity_err !== 1'b0) begin
      errors++; $display("FAIL rx55_errs got fe=%b pe=%b want 0 0", rx_frame_err, rx_parity_err); end
    checks++; if (lat < 0 || lat > 2 + 8 * OS) begin
      errors++; $display("FAIL rx55_latency got %0d want 0..%0d", lat, 2 + 8 * OS); end
    pulse_rx_ready();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx55_consume got rx_valid=%b want 0", rx_valid); end
    checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL rx55_hold got %h want 55", rx_data); end
  endtask

  task automatic test_false_start();
    int n0 = rv_rise_cnt;
    @(negedge clock);
    RXD = 1'b0;
    repeat (25) @(negedge clock);
    RXD = 1'b1;
    repeat (2 * BIT) @(negedge clock);
    checks++; if (rv_rise_cnt !== n0 || rx_valid !== 1'b0) begin
      errors++; $display("FAIL glitch_no_word got rises=%0d rx_valid=%b want 0 0", rv_rise_cnt - n0, rx_valid); end
    drive_rx_frame(8'h0F, 0, 1'b0);
    checks++; if (rv_rise_cnt !== n0 + 1) begin errors++; $display("FAIL rx0f_count got %0d want 1", rv_rise_cnt - n0); end
    checks++; if (rx_data !== 8'h0F) begin errors++; $display("FAIL rx0f_data got %h want 0f", rx_data); end
    pulse_rx_ready();
  endtask

  task automatic test_frame_err();
    int n0 = rv_rise_cnt;
    int o0 = ovr_cnt;
    drive_rx_frame(8'h12, 10, 1'b0);
    checks++; if (rv_rise_cnt !== n0 + 1 || rx_valid !== 1'b1) begin
      errors++; $display("FAIL ferr_count got %0d valid=%b want 1 1", rv_rise_cnt - n0, rx_valid); end
    checks++; if (rx_data !== 8'h12) begin errors++; $display("FAIL ferr_data got %h want 12", rx_data); end
    checks++; if (rx_frame_err !== 1'b1) begin errors++; $display("FAIL ferr_flag got %b want 1", rx_frame_err); end
    checks++; if (ovr_cnt !== o0) begin errors++; $display("FAIL ferr_break_overrun got %0d want 0", ovr_cnt - o0); end
    pulse_rx_ready();
    drive_rx_frame(8'h34, 0, 1'b0);
    checks++; if (rx_data !== 8'h34 || rx_valid !== 1'b1) begin
      errors++; $display("FAIL after_break_data got %h valid=%b want 34 1", rx_data, rx_valid); end
    checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL after_break_ferr got %b want 0", rx_frame_err); end
    pulse_rx_ready();
  endtask

  task automatic test_overrun();
    int o0 = ovr_cnt;
    rx_ready = 1'b0;
    drive_rx_frame(8'h01, 0, 1'b0);
    drive_rx_frame(8'h02, 0, 1'b0);
    checks++; if (rx_data !== 8'h01) begin errors++; $display("FAIL ovr_data got %h want 01", rx_data); end
    checks++; if (ovr_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_pulses got %0d want 1", ovr_cnt - o0); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b want 1", rx_valid); end
    pulse_rx_ready();
    checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h01) begin
      errors++; $display("FAIL ovr_consume got valid=%b data=%h want 0 01", rx_valid, rx_data); end
  endtask

  task automatic test_tx();
    int low_cnt = 0;
    bit done = 1'b0;
    @(negedge clock);
    tx_data = 8'hA3;
    tx_valid = 1'b1;
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL tx_idle_ready got %b want 1", tx_ready); end
    @(posedge clock);
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clock);
      if (i == 0) tx_valid = 1'b0;
      if (tx_ready) done = 1'b1;
      else low_cnt++;
      if (!done && (i % BIT) == BIT / 2 && (i / BIT) < NBITS) begin
        checks++;
        if (TXD !== A3_BITS[i / BIT]) begin
          errors++; $display("FAIL tx_a3_bit%0d got %b want %b", i / BIT, TXD, A3_BITS[i / BIT]);
        end
      end
    end
    checks++; if (low_cnt !== NBITS * BIT) begin
      errors++; $display("FAIL tx_busy_len got %0d want %0d", low_cnt, NBITS * BIT); end
  endtask

  task automatic test_back_to_back();
    int hi_cnt = 0;
    bit done = 1'b0;
    @(negedge clock);
    tx_data = 8'h5A;
    tx_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    tx_data = 8'h3C;
    for (int i = 0; i < 3000 && !done; i++) begin
      if (tx_ready) done = 1'b1;
      else @(negedge clock);
    end
    checks++; if (!done) begin errors++; $display("FAIL b2b_timeout got tx_ready=0 want 1"); end
    for (int i = 0; i < NBITS * BIT; i++) begin
      @(negedge clock);
      if (i == 0) begin
        tx_valid = 1'b0;
        if (tx_ready) hi_cnt++;
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_gap got tx_ready=%b want 0", tx_ready); end
      end
      if ((i % BIT) == BIT / 2) begin
        checks++;
        if (TXD !== B2_BITS[i / BIT]) begin
          errors++; $display("FAIL b2b_3c_bit%0d got %b want %b", i / BIT, TXD, B2_BITS[i / BIT]);
        end
      end
    end
    repeat (4) @(negedge clock);
    checks++; if (tx_ready !== 1'b1 || hi_cnt !== 0) begin
      errors++; $display("FAIL b2b_end got ready=%b gapcycles=%0d want 1 0", tx_ready, hi_cnt); end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    drive_rx_frame(8'h07, 0, 1'b1);
    checks++; if (rx_data !== 8'h07 || rx_parity_err !== 1'b1) begin
      errors++; $display("FAIL par_bad got data=%h pe=%b want 07 1", rx_data, rx_parity_err); end
    pulse_rx_ready();
    drive_rx_frame(8'h07, 0, 1'b0);
    checks++; if (rx_data !== 8'h07 || rx_parity_err !== 1'b0) begin
      errors++; $display("FAIL par_good got data=%h pe=%b want 07 0", rx_data, rx_parity_err); end
    pulse_rx_ready();
    @(negedge clock);
    tx_data = 8'h07;
    tx_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    tx_valid = 1'b0;
    repeat (9 * BIT + BIT / 2 - 1) @(negedge clock);
    checks++; if (TXD !== 1'b1) begin errors++; $display("FAIL par_tx_bit got %b want 1", TXD); end
    repeat (2 * BIT) @(negedge clock);
  endtask
`endif

  task automatic test_reset_mid_tx();
    drive_rx_frame(8'h66, 0, 1'b0);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h66) begin
      errors++; $display("FAIL prereset_rx got valid=%b data=%h want 1 66", rx_valid, rx_data); end
    @(negedge clock);
    tx_data = 8'hA3;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    repeat (200) @(negedge clock);
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL midtx_busy got %b want 0", tx_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if (TXD !== 1'b1 || tx_ready !== 1'b1) begin
      errors++; $display("FAIL async_rst_tx got txd=%b ready=%b want 1 1", TXD, tx_ready); end
    checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
      errors++; $display("FAIL async_rst_rx got valid=%b data=%h want 0 00", rx_valid, rx_data); end
    @(negedge clock);
    rst_n = 1'b1;
    repeat (3 * BIT) @(negedge clock);
    checks++; if (TXD !== 1'b1 || tx_ready !== 1'b1 || rx_valid !== 1'b0) begin
      errors++; $display("FAIL post_rst_idle got txd=%b ready=%b rxv=%b want 1 1 0", TXD, tx_ready, rx_valid); end
  endtask

  initial begin
    test_reset();
    test_rx_basic();
    test_false_start();
    test_frame_err();
    test_overrun();
    test_tx();
    test_back_to_back();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    test_reset_mid_tx();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
